// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU op encodings, control-field widths
// and the all-zero bubble used when squashing or stalling a pipeline entry.
package mips_pkg;

   localparam logic [1:0] ALU_OP_MEM   = 2'b00;
   localparam logic [1:0] ALU_OP_BEQ   = 2'b01;
   localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

   localparam int WB_W = 2;
   localparam int M_W  = 3;
   localparam int EX_W = 4;

   // wb = {reg_write, mem_to_reg}; m = {branch, mem_read, mem_write};
   // ex = {reg_dst, alu_op[1:0], alu_src}
   typedef struct packed {
      logic [WB_W-1:0] wb;
      logic [M_W-1:0]  m;
      logic [EX_W-1:0] ex;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the instruction in DECODE and a load in
// EXECUTE; a concurrent flush overrides the stall so fetch can redirect.
module hazard_detect #(
   parameter int REG_W = 5
) (
   input  logic             ex_valid,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rt,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             flush,
   output logic             haz,
   output logic             pc_write,
   output logic             if_id_write
);

   // $0 is hardwired to zero, so a load into it never creates a dependency
   assign haz = ex_valid & ex_mem_read & id_valid & (|ex_rt) &
                ((ex_rt == id_rs) | (ex_rt == id_rt));

   assign pc_write    = ~haz | flush;
   assign if_id_write = ~haz | flush;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures decoded control and operands, inserts
// bubbles on flush or load-use hazard, and counts hazard bubbles.
module id_ex_stage_reg
   import mips_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              hold,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [WB_W-1:0]   id_wb,
   input  logic [M_W-1:0]    id_m,
   input  logic [EX_W-1:0]   id_ex,
   input  logic [DATA_W-1:0] id_npc,
   input  logic [DATA_W-1:0] id_rd1,
   input  logic [DATA_W-1:0] id_rd2,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic [REG_W-1:0]  id_rd,
   output logic              ex_valid,
   output logic [WB_W-1:0]   ex_wb,
   output logic [M_W-1:0]    ex_m,
   output logic [1:0]        ex_alu_op,
   output logic              ex_reg_dst,
   output logic              ex_alu_src,
   output logic [5:0]        ex_funct,
   output logic [DATA_W-1:0] ex_npc,
   output logic [DATA_W-1:0] ex_rd1,
   output logic [DATA_W-1:0] ex_rd2,
   output logic [DATA_W-1:0] ex_imm,
   output logic [REG_W-1:0]  ex_rt,
   output logic [REG_W-1:0]  ex_rd,
   output logic              pc_write,
   output logic              if_id_write,
   output logic [CNT_W-1:0]  stall_cnt
);

   ctrl_t ex_ctrl;
   logic  haz;

   hazard_detect #(.REG_W(REG_W)) u_haz (
      .ex_valid    (ex_valid),
      .ex_mem_read (ex_ctrl.m[1]),
      .ex_rt       (ex_rt),
      .id_valid    (id_valid),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .flush       (flush),
      .haz         (haz),
      .pc_write    (pc_write),
      .if_id_write (if_id_write)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid  <= 1'b0;
         ex_ctrl   <= CTRL_BUBBLE;
         ex_funct  <= '0;
         ex_npc    <= '0;
         ex_rd1    <= '0;
         ex_rd2    <= '0;
         ex_imm    <= '0;
         ex_rt     <= '0;
         ex_rd     <= '0;
         stall_cnt <= '0;
      end else if (!hold) begin
         if (flush || haz) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= CTRL_BUBBLE;
            ex_funct <= '0;
            ex_npc   <= '0;
            ex_rd1   <= '0;
            ex_rd2   <= '0;
            ex_imm   <= '0;
            ex_rt    <= '0;
            ex_rd    <= '0;
            // a flushed hazard is not a real stall: fetch is redirected anyway
            if (!flush && (stall_cnt != '1))
               stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            ex_valid <= id_valid;
            ex_ctrl  <= id_valid ? ctrl_t'({id_wb, id_m, id_ex}) : CTRL_BUBBLE;
            ex_funct <= id_imm[5:0];
            ex_npc   <= id_npc;
            ex_rd1   <= id_rd1;
            ex_rd2   <= id_rd2;
            ex_imm   <= id_imm;
            ex_rt    <= id_rt;
            ex_rd    <= id_rd;
         end
      end
   end

   assign ex_wb      = ex_ctrl.wb;
   assign ex_m       = ex_ctrl.m;
   assign ex_reg_dst = ex_ctrl.ex[3];
   assign ex_alu_op  = ex_ctrl.ex[2:1];
   assign ex_alu_src = ex_ctrl.ex[0];

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed vector table, load-use/saturation
// sequences, randomized traffic against an entry-level model, async reset.
module tb_id_ex_stage_reg;
   import mips_pkg::*;

   localparam int DW = 32;
   localparam int RW = 5;
   localparam int CW = 16;
   localparam int SW = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, hold, flush, id_valid;
   logic [1:0]    id_wb;
   logic [2:0]    id_m;
   logic [3:0]    id_ex;
   logic [DW-1:0] id_npc, id_rd1, id_rd2, id_imm;
   logic [RW-1:0] id_rs, id_rt, id_rd;

   logic          ex_valid, ex_reg_dst, ex_alu_src, pc_write, if_id_write;
   logic [1:0]    ex_wb, ex_alu_op;
   logic [2:0]    ex_m;
   logic [5:0]    ex_funct;
   logic [DW-1:0] ex_npc, ex_rd1, ex_rd2, ex_imm;
   logic [RW-1:0] ex_rt, ex_rd;
   logic [CW-1:0] stall_cnt;

   // narrow-counter copy, used to observe saturation
   logic          s_valid, s_reg_dst, s_alu_src, s_pc_write, s_if_id_write;
   logic [1:0]    s_wb, s_alu_op;
   logic [2:0]    s_m;
   logic [5:0]    s_funct;
   logic [DW-1:0] s_npc, s_rd1, s_rd2, s_imm;
   logic [RW-1:0] s_rt, s_rd;
   logic [SW-1:0] s_stall_cnt;

   id_ex_stage_reg #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .id_valid(id_valid),
      .id_wb(id_wb), .id_m(id_m), .id_ex(id_ex), .id_npc(id_npc), .id_rd1(id_rd1),
      .id_rd2(id_rd2), .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .ex_valid(ex_valid), .ex_wb(ex_wb), .ex_m(ex_m), .ex_alu_op(ex_alu_op),
      .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_funct(ex_funct),
      .ex_npc(ex_npc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
      .ex_rt(ex_rt), .ex_rd(ex_rd), .pc_write(pc_write), .if_id_write(if_id_write),
      .stall_cnt(stall_cnt));

   id_ex_stage_reg #(.DATA_W(DW), .REG_W(RW), .CNT_W(SW)) dut_s (
      .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .id_valid(id_valid),
      .id_wb(id_wb), .id_m(id_m), .id_ex(id_ex), .id_npc(id_npc), .id_rd1(id_rd1),
      .id_rd2(id_rd2), .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .ex_valid(s_valid), .ex_wb(s_wb), .ex_m(s_m), .ex_alu_op(s_alu_op),
      .ex_reg_dst(s_reg_dst), .ex_alu_src(s_alu_src), .ex_funct(s_funct),
      .ex_npc(s_npc), .ex_rd1(s_rd1), .ex_rd2(s_rd2), .ex_imm(s_imm),
      .ex_rt(s_rt), .ex_rd(s_rd), .pc_write(s_pc_write), .if_id_write(s_if_id_write),
      .stall_cnt(s_stall_cnt));

   // reference model: the instruction sitting in EXECUTE plus a bubble count
   typedef struct {
      logic          valid;
      logic [1:0]    wb;
      logic [2:0]    m;
      logic [3:0]    ex;
      logic [5:0]    funct;
      logic [DW-1:0] npc, rd1, rd2, imm;
      logic [RW-1:0] rt, rd;
   } ent_t;

   ent_t        mdl;
   int unsigned mcnt;
   int          n_chk = 0;
   int          n_fail = 0;

   typedef struct {
      logic          hold, flush, v;
      logic [1:0]    wb;
      logic [2:0]    m;
      logic [3:0]    ex;
      logic [DW-1:0] imm, rd1;
      logic [RW-1:0] rs, rt, rd;
      logic          e_pcw, e_valid;
      logic [1:0]    e_alu;
      logic [5:0]    e_funct;
      logic [DW-1:0] e_rd1;
      logic [CW-1:0] e_cnt;
   } vec_t;

   vec_t tbl[14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic ent_t empty_ent();
      ent_t e;
      e.valid = 1'b0; e.wb = '0; e.m = '0; e.ex = '0; e.funct = '0;
      e.npc = '0; e.rd1 = '0; e.rd2 = '0; e.imm = '0; e.rt = '0; e.rd = '0;
      return e;
   endfunction

   function automatic bit model_haz();
      return mdl.valid && mdl.m[1] && id_valid && (mdl.rt != 0) &&
             ((mdl.rt == id_rs) || (mdl.rt == id_rt));
   endfunction

   task automatic check_outs(input string tag);
      int unsigned sat;
      sat = (mcnt > 7) ? 7 : mcnt;
      chk({tag, ".ctrl"},
          {ex_valid, ex_wb, ex_m, ex_reg_dst, ex_alu_op, ex_alu_src, ex_funct},
          {mdl.valid, mdl.wb, mdl.m, mdl.ex, mdl.funct});
      chk({tag, ".npc"}, ex_npc, mdl.npc);
      chk({tag, ".rd1"}, ex_rd1, mdl.rd1);
      chk({tag, ".rd2"}, ex_rd2, mdl.rd2);
      chk({tag, ".imm"}, ex_imm, mdl.imm);
      chk({tag, ".rt_rd"}, {ex_rt, ex_rd}, {mdl.rt, mdl.rd});
      chk({tag, ".stall_cnt"}, stall_cnt, mcnt);
      chk({tag, ".sat_cnt"}, s_stall_cnt, sat);
   endtask

   // inputs already applied; check fetch control, clock once, check EX entry
   task automatic step(input string tag);
      ent_t nxt;
      bit   h;
      #1;
      h = model_haz();
      chk({tag, ".pc_write"}, pc_write, !h || flush);
      chk({tag, ".if_id_write"}, if_id_write, !h || flush);
      nxt = mdl;
      if (!hold) begin
         if (flush || h) begin
            nxt = empty_ent();
            if (!flush && mcnt < 65535) mcnt++;
         end else begin
            nxt.valid = id_valid;
            nxt.wb    = id_valid ? id_wb : 2'b0;
            nxt.m     = id_valid ? id_m  : 3'b0;
            nxt.ex    = id_valid ? id_ex : 4'b0;
            nxt.funct = id_imm[5:0];
            nxt.npc = id_npc; nxt.rd1 = id_rd1; nxt.rd2 = id_rd2; nxt.imm = id_imm;
            nxt.rt = id_rt; nxt.rd = id_rd;
         end
      end
      @(posedge clk);
      #1;
      mdl = nxt;
      check_outs(tag);
   endtask

   task automatic apply(input logic h, input logic f, input logic v, input logic [1:0] wb,
                        input logic [2:0] m, input logic [3:0] ex, input logic [DW-1:0] imm,
                        input logic [DW-1:0] rd1, input logic [RW-1:0] rs,
                        input logic [RW-1:0] rt, input logic [RW-1:0] rd);
      hold = h; flush = f; id_valid = v; id_wb = wb; id_m = m; id_ex = ex;
      id_imm = imm; id_rd1 = rd1; id_rd2 = rd1 + 1; id_npc = rd1 + 4;
      id_rs = rs; id_rt = rt; id_rd = rd;
   endtask

   initial begin
      // {hold,flush,valid,wb,m,ex,imm,rd1,rs,rt,rd, pcw,valid,alu,funct,rd1,cnt}
      tbl[0]  = '{0,0,1,2'b10,3'b000,{1'b0,ALU_OP_RTYPE,1'b0},32'h20,5,1,2,3,  1,1,ALU_OP_RTYPE,6'h20,5,0};
      tbl[1]  = '{0,0,1,2'b11,3'b010,{1'b0,ALU_OP_MEM,1'b1},32'h4,100,1,8,0,   1,1,ALU_OP_MEM,6'h04,100,0};
      tbl[2]  = '{0,0,1,2'b10,3'b000,{1'b0,ALU_OP_RTYPE,1'b0},32'h20,9,8,9,10, 0,0,2'b00,6'h00,0,1};
      tbl[3]  = '{0,0,1,2'b10,3'b000,{1'b0,ALU_OP_RTYPE,1'b0},32'h20,9,8,9,10, 1,1,ALU_OP_RTYPE,6'h20,9,1};
      tbl[4]  = '{0,0,1,2'b11,3'b010,{1'b0,ALU_OP_MEM,1'b1},32'h0,50,2,0,0,    1,1,ALU_OP_MEM,6'h00,50,1};
      tbl[5]  = '{0,0,1,2'b10,3'b000,{1'b0,ALU_OP_RTYPE,1'b0},32'h20,11,0,0,4, 1,1,ALU_OP_RTYPE,6'h20,11,1};
      tbl[6]  = '{0,0,1,2'b11,3'b010,{1'b0,ALU_OP_MEM,1'b1},32'h8,200,3,8,0,   1,1,ALU_OP_MEM,6'h08,200,1};
      tbl[7]  = '{0,1,1,2'b10,3'b000,{1'b0,ALU_OP_RTYPE,1'b0},32'h20,12,8,5,6, 1,0,2'b00,6'h00,0,1};
      tbl[8]  = '{0,0,1,2'b11,3'b010,{1'b0,ALU_OP_MEM,1'b1},32'h0C,300,3,8,0,  1,1,ALU_OP_MEM,6'h0C,300,1};
      tbl[9]  = '{1,1,1,2'b10,3'b000,{1'b0,ALU_OP_RTYPE,1'b0},32'h20,13,8,5,6, 1,1,ALU_OP_MEM,6'h0C,300,1};
      tbl[10] = '{1,1,1,2'b10,3'b000,{1'b0,ALU_OP_RTYPE,1'b0},32'h20,13,8,5,6, 1,1,ALU_OP_MEM,6'h0C,300,1};
      tbl[11] = '{1,1,1,2'b10,3'b000,{1'b0,ALU_OP_RTYPE,1'b0},32'h20,13,8,5,6, 1,1,ALU_OP_MEM,6'h0C,300,1};
      tbl[12] = '{0,0,1,2'b10,3'b000,{1'b0,ALU_OP_RTYPE,1'b0},32'h20,13,8,5,6, 0,0,2'b00,6'h00,0,2};
      tbl[13] = '{0,0,0,2'b10,3'b001,{1'b1,ALU_OP_RTYPE,1'b1},32'h15,77,1,2,3, 1,0,2'b00,6'h15,77,2};

      rst_n = 1'b0;
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      mdl = empty_ent();
      mcnt = 0;
      #1;
      check_outs("reset");
      chk("reset.pc_write", pc_write, 1'b1);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         string t;
         t = $sformatf("vec%0d", i);
         apply(tbl[i].hold, tbl[i].flush, tbl[i].v, tbl[i].wb, tbl[i].m, tbl[i].ex,
               tbl[i].imm, tbl[i].rd1, tbl[i].rs, tbl[i].rt, tbl[i].rd);
         #1;
         chk({t, ".tbl_pcw"}, pc_write, tbl[i].e_pcw);
         step(t);
         chk({t, ".tbl_ex"}, {ex_valid, ex_alu_op, ex_funct, ex_rd1},
             {tbl[i].e_valid, tbl[i].e_alu, tbl[i].e_funct, tbl[i].e_rd1});
         chk({t, ".tbl_cnt"}, stall_cnt, tbl[i].e_cnt);
      end

      // repeated load-use pairs: the 3-bit copy must pin at 7
      for (int i = 0; i < 10; i++) begin
         apply(0, 0, 1, 2'b11, 3'b010, 4'b0001, 32'h0, 32'h1000 + i, 1, 8, 0);
         step("sat.lw");
         apply(0, 0, 1, 2'b10, 3'b000, 4'b0100, 32'h20, 32'h2000 + i, 8, 2, 3);
         step("sat.use");
      end
      chk("sat.narrow", s_stall_cnt, 3'h7);
      chk("sat.wide", stall_cnt, 16'd12);

      for (int i = 0; i < 400; i++) begin
         apply($urandom_range(7) == 0, $urandom_range(7) == 0, $urandom_range(3) != 0,
               2'($urandom), 3'($urandom), 4'($urandom), $urandom, $urandom,
               5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)));
         step($sformatf("rnd%0d", i));
      end

      // async reset mid-run, away from the clock edge
      apply(0, 0, 1, 2'b11, 3'b010, 4'b0001, 32'h0, 32'h55, 1, 8, 0);
      step("pre_rst");
      #2;
      rst_n = 1'b0;
      #1;
      mdl = empty_ent();
      mcnt = 0;
      check_outs("midrst");
      chk("midrst.pc_write", pc_write, 1'b1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         apply($urandom_range(7) == 0, $urandom_range(7) == 0, $urandom_range(3) != 0,
               2'($urandom), 3'($urandom), 4'($urandom), $urandom, $urandom,
               5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)));
         step($sformatf("post%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
